aes_decrypt_top: RTL and testbench
==================================

Name: aes_decrypt_top

Overview:
- Iterative AES-128 decryption core, the inverse-direction companion of the aes_top encryptor.
- Accepts one 128-bit ciphertext and key per start pulse and returns the FIPS-197 plaintext.
- Expands the key on the fly, then runs 10 inverse rounds at one round per clock.
- Sits beside aes_top on the same clock domain; handshake style matches aes_top: start pulse in, one-cycle valid pulse out.

Parameters:
- NR, 10, number of AES rounds; fixed for AES-128; other values unsupported.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- key_in  in  128  cipher key, byte 0 at MSBs; sampled with start.
- ciphertext_in  in  128  input block, byte 0 at MSBs; sampled with start.
- plaintext_out  out  128  result; held until the next completion.
- valid_out  out  1  one-cycle pulse when plaintext_out is updated.
- busy  out  1  high from the cycle after start is accepted until valid_out is asserted.

Behaviour:
- Reset (async, rst=1): state IDLE; plaintext_out=0, valid_out=0, busy=0; round counter, key registers and state register all cleared.
- The state register is never observable before completion.
- IDLE:
  - start=1 at edge E0 latches key_in into rk[0] and ciphertext_in into the state register.
  - Sets busy=1 and moves to KEYEXP with counter i=1.
- KEYEXP, edges E1..E10:
  - Computes rk[i] from rk[i-1] using RotWord, SubWord (forward S-box) and Rcon[i].
  - At i=10 also applies state <= state XOR rk[10], then moves to ROUND with r=9.
- ROUND, edges E11..E20:
  - For r=9..1: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])).
  - For r=0: plaintext_out <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]); valid_out=1 for the following cycle; busy=0; return to IDLE.
- Latency: start sampled at E0 leads to valid_out high in the cycle after E20, exactly one cycle wide.
- start while busy=1: ignored; inputs are not resampled; the in-flight operation is unaffected.
- start in the valid_out cycle: accepted, because the FSM is already in IDLE; valid_out still deasserts next cycle.
- rst mid-operation: immediate abort; no valid_out; a subsequent start runs the full 20 cycles.
- GF(2^8) arithmetic uses reduction polynomial 0x11B. InvMixColumns coefficients are 0e, 0b, 0d, 09.
- All byte ordering is identical to aes_top, so round-trip encrypt→decrypt returns the original block.

Optional Feature:
- AES_DEC_KEY_CACHE_EN defined:
  - The core retains rk[0..10] and a cache_valid flag after each operation.
  - If start arrives with key_in == rk[0] and cache_valid=1, KEYEXP is skipped: state <= ciphertext_in XOR rk[10] at E0, ROUND runs E1..E10, valid_out follows E10 (latency 10).
  - rst clears cache_valid.
- Not defined: no comparator, no cache flag; every operation takes 20 cycles.

Decomposition:
- Package aes_dec_pkg:
  - Forward and inverse S-box functions.
  - Rcon table.
  - gf_mul2, gf_mul9, gf_mulB, gf_mulD, gf_mulE functions.
  - NR constant.
  - FSM state typedef {IDLE, KEYEXP, ROUND}.
- Sub-module aes_inv_round (combinational):
  - Inputs: state, round key, final flag.
  - Outputs the next state; applies InvMixColumns only when final=0.
- Top level holds the FSM, counters, key registers and output registers.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a → plaintext_out=00112233445566778899aabbccddeeff; valid_out one cycle, 20 cycles after start.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32 → plaintext_out=3243f6a8885a308d313198a2e0370734.
- start held high for 25 cycles with C.1 inputs, and inputs changed while busy → exactly one valid_out; result equals the C.1 plaintext.
- rst pulsed 7 cycles after start → valid_out never asserts; plaintext_out=0; busy=0. A new App. B start then completes correctly in 20 cycles.
- Back-to-back: second start (C.1) in the valid_out cycle of an App. B operation → both plaintexts produced; valid pulses 21 cycles apart.
- With AES_DEC_KEY_CACHE_EN: two consecutive C.1 decrypts → first latency 20, second latency 10, both outputs correct. Different key → latency 20. Without the macro, both latencies are 20.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES-128 decryption core.
// Holds the forward and inverse S-boxes, the Rcon table, the GF(2^8)
// multiply helpers used by InvMixColumns, the round count NR, the FSM
// state type and the on-the-fly key expansion step.
// The optional macro AES_DEC_KEY_CACHE_EN is handled in aes_decrypt_top;
// nothing in this package depends on it.
package aes_dec_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} fsm_state_e;

  // Tables are stored with entry 0 in the top byte, so entry x lives at
  // bit offset 8*(255-x); {~x, 3'b000} computes exactly that offset.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return INV_SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulB(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulD(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mulE(input logic [7:0] x);
    return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ gf_mul2(x);
  endfunction

  // One forward key-schedule step: rk[i] from rk[i-1] and Rcon[i].
  function automatic logic [127:0] key_expand(input logic [127:0] prev,
                                               input logic [3:0]   rnd);
    logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;
    w0   = prev[127:96];
    w1   = prev[95:64];
    w2   = prev[63:32];
    w3   = prev[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rcon(rnd), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round.
// Computes InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), key)),
// skipping InvMixColumns when final_round is set (the last round).
// Ports:
//   state_in    - 128-bit state, byte 0 at MSBs, column-major
//   round_key   - 128-bit round key for this round
//   final_round - 1 = last round, no InvMixColumns
//   state_out   - next state
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0] ark [16];
  logic [7:0] imc [16];

  // Byte n sits at row n%4, column n/4. InvShiftRows rotates row r right
  // by r, so output (r,c) takes input (r,(c-r) mod 4).
  for (genvar n = 0; n < 16; n++) begin : g_byte
    localparam int R   = n % 4;
    localparam int C   = n / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    assign ark[n] = inv_sbox(state_in[127-8*SRC -: 8]) ^ round_key[127-8*n -: 8];
    assign state_out[127-8*n -: 8] = final_round ? ark[n] : imc[n];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign imc[4*c+0] = gf_mulE(ark[4*c]) ^ gf_mulB(ark[4*c+1]) ^ gf_mulD(ark[4*c+2]) ^ gf_mul9(ark[4*c+3]);
    assign imc[4*c+1] = gf_mul9(ark[4*c]) ^ gf_mulE(ark[4*c+1]) ^ gf_mulB(ark[4*c+2]) ^ gf_mulD(ark[4*c+3]);
    assign imc[4*c+2] = gf_mulD(ark[4*c]) ^ gf_mul9(ark[4*c+1]) ^ gf_mulE(ark[4*c+2]) ^ gf_mulB(ark[4*c+3]);
    assign imc[4*c+3] = gf_mulB(ark[4*c]) ^ gf_mulD(ark[4*c+1]) ^ gf_mul9(ark[4*c+2]) ^ gf_mulE(ark[4*c+3]);
  end

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryption core.
// A start pulse loads key and ciphertext; the key schedule is expanded
// forward one round key per clock (10 cycles) and kept in rk[0..10], then
// the 10 inverse rounds run one per clock using the keys in reverse order.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start          - request, only sampled while busy=0
//   key_in         - 128-bit cipher key, byte 0 at MSBs
//   ciphertext_in  - 128-bit block, byte 0 at MSBs
//   plaintext_out  - result, held until the next completion
//   valid_out      - one-cycle pulse when plaintext_out updates
//   busy           - high while an operation is in flight
// Optional macro AES_DEC_KEY_CACHE_EN: when defined, a start with the same
// key as the previous completed expansion reuses rk[0..10] and skips the
// key-expansion phase (latency 10 instead of 20).
module aes_decrypt_top
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] ciphertext_in,
  output logic [127:0] plaintext_out,
  output logic         valid_out,
  output logic         busy
);

  fsm_state_e   fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk_q [11];
  logic [127:0] rk_d [11];
  logic [127:0] pt_q, pt_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
  logic         cache_valid_q, cache_valid_d;
`endif

  logic [127:0] rk_next;
  logic [127:0] round_out;

  // In KEYEXP the counter is the index of the key being produced;
  // in ROUND it is the index of the key being consumed.
  assign rk_next = key_expand(rk_q[cnt_q - 4'd1], cnt_q);

  aes_inv_round u_inv_round (
    .state_in    (blk_q),
    .round_key   (rk_q[cnt_q]),
    .final_round (cnt_q == 4'd0),
    .state_out   (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    pt_d    = pt_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_valid_d = cache_valid_q;
`endif
    case (fsm_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_valid_q && (key_in == rk_q[0])) begin
            // Schedule already present: do the initial AddRoundKey now.
            blk_d = ciphertext_in ^ rk_q[10];
            cnt_d = NR - 4'd1;
            fsm_d = ROUND;
          end else begin
            rk_d[0]       = key_in;
            blk_d         = ciphertext_in;
            cnt_d         = 4'd1;
            fsm_d         = KEYEXP;
            cache_valid_d = 1'b0;
          end
`else
          rk_d[0] = key_in;
          blk_d   = ciphertext_in;
          cnt_d   = 4'd1;
          fsm_d   = KEYEXP;
`endif
        end
      end
      KEYEXP: begin
        rk_d[cnt_q] = rk_next;
        if (cnt_q == NR) begin
          // rk[10] is not registered yet, so use the freshly expanded value.
          blk_d = blk_q ^ rk_next;
          cnt_d = NR - 4'd1;
          fsm_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_valid_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        if (cnt_q == 4'd0) begin
          pt_d    = round_out;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          fsm_d   = IDLE;
        end else begin
          blk_d = round_out;
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      rk_q    <= '{default: '0};
      pt_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_valid_q <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
      pt_q    <= pt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  assign plaintext_out = pt_q;
  assign valid_out     = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Testbench for aes_decrypt_top using FIPS-197 vectors.
// Table-driven decrypts plus hand-written sequences for held start,
// mid-operation reset and back-to-back starts. Honours AES_DEC_KEY_CACHE_EN
// for the expected latency of a repeated key.
module tb_aes_decrypt_top;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int REPEAT_LAT = 10;
`else
  localparam int REPEAT_LAT = 20;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] ciphertext_in;
  logic [127:0] plaintext_out;
  logic         valid_out;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs [5];

  aes_decrypt_top dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .key_in        (key_in),
    .ciphertext_in (ciphertext_in),
    .plaintext_out (plaintext_out),
    .valid_out     (valid_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge; the following posedge samples the request.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] ct);
    key_in        = key;
    ciphertext_in = ct;
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  // Counts edges after the accepting edge until valid_out is seen.
  task automatic waitValid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic doReset();
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
  endtask

  initial begin
    int lat, lat2, seen, first_k, second_k;
    logic [127:0] pt_first, pt_second;
    logic busy_k21;

    rst = 1'b1; start = 1'b0; key_in = '0; ciphertext_in = '0;
    vecs[0] = '{"c1_first",  C1_KEY, C1_CT, C1_PT, 20};
    vecs[1] = '{"appb",      B_KEY,  B_CT,  B_PT,  20};
    vecs[2] = '{"c1_newkey", C1_KEY, C1_CT, C1_PT, 20};
    vecs[3] = '{"c1_repeat", C1_KEY, C1_CT, C1_PT, REPEAT_LAT};
    vecs[4] = '{"appb_diff", B_KEY,  B_CT,  B_PT,  20};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_pt",    plaintext_out, 128'h0);
    checkOutput("reset_valid", 128'(valid_out), 128'h0);
    checkOutput("reset_busy",  128'(busy), 128'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].key, vecs[v].ct);
      checkOutput({vecs[v].name, "_busy"}, 128'(busy), 128'h1);
      waitValid(lat);
      checkOutput({vecs[v].name, "_pt"}, plaintext_out, vecs[v].pt);
      checkOutput({vecs[v].name, "_lat"}, 128'(lat), 128'(vecs[v].lat));
      checkOutput({vecs[v].name, "_busy_done"}, 128'(busy), 128'h0);
      @(negedge clk);
      checkOutput({vecs[v].name, "_pulse"}, 128'(valid_out), 128'h0);
    end

    // Start held for 25 edges; inputs changed while busy. The start still
    // high in the valid cycle is a legal new request with the new inputs.
    doReset();
    key_in = C1_KEY; ciphertext_in = C1_CT; start = 1'b1;
    seen = 0; first_k = -1; second_k = -1; pt_first = '0; pt_second = '0; busy_k21 = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (k == 5) begin key_in = B_KEY; ciphertext_in = B_CT; end
      if (k == 24) start = 1'b0;
      if (k == 21) busy_k21 = busy;
      if (valid_out === 1'b1) begin
        if (k <= 25) seen++;
        if (first_k < 0) begin first_k = k; pt_first = plaintext_out; end
        else if (second_k < 0) begin second_k = k; pt_second = plaintext_out; end
      end
    end
    checkOutput("held_valid_count", 128'(seen), 128'h1);
    checkOutput("held_first_lat",   128'(first_k), 128'd20);
    checkOutput("held_first_pt",    pt_first, C1_PT);
    checkOutput("held_reaccept",    128'(busy_k21), 128'h1);
    checkOutput("held_second_lat",  128'(second_k), 128'd41);
    checkOutput("held_second_pt",   pt_second, B_PT);

    // Reset 7 cycles into an operation.
    doReset();
    applyStimulus(C1_KEY, C1_CT);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (valid_out === 1'b1) seen++;
    end
    checkOutput("abort_no_valid", 128'(seen), 128'h0);
    checkOutput("abort_pt",       plaintext_out, 128'h0);
    checkOutput("abort_busy",     128'(busy), 128'h0);
    applyStimulus(B_KEY, B_CT);
    waitValid(lat);
    checkOutput("abort_next_pt",  plaintext_out, B_PT);
    checkOutput("abort_next_lat", 128'(lat), 128'd20);

    // Back-to-back: second start lands in the valid cycle.
    doReset();
    applyStimulus(B_KEY, B_CT);
    waitValid(lat);
    checkOutput("b2b_first_pt", plaintext_out, B_PT);
    applyStimulus(C1_KEY, C1_CT);
    checkOutput("b2b_valid_drop", 128'(valid_out), 128'h0);
    waitValid(lat2);
    checkOutput("b2b_spacing",   128'(lat2 + 1), 128'd21);
    checkOutput("b2b_second_pt", plaintext_out, C1_PT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
